memory_access: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline.
- Consumes `execute_data_t` produced by the execute stage and performs loads and stores on the data bus (`dbus`).
- Produces `memory_data_t` for writeback.
- Owns the request/response handshake with the data bus and raises `stallM` while an access is outstanding.

---
 rtl/memory_access_pkg.sv | 79 +++++++
 rtl/memory_access_memdata_align.sv | 43 ++++
 rtl/memory_access.sv | 143 ++++++++++++++
 tb/tb_memory_access.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: pipeline payloads, data-bus request/response,
// access-size encoding and the memory-stage FSM state.
package memory_access_pkg;

  localparam int ADDR_W = 64;
  localparam int XLEN   = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memsext;
    msize_t msize;
  } ctl_t;

  typedef struct packed {
    logic            valid;
    logic [63:0]     pc;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] srcb;
    logic [4:0]      dst;
    ctl_t            ctl;
  } execute_data_t;

  typedef struct packed {
    logic            valid;
    logic [63:0]     pc;
    logic [4:0]      dst;
    ctl_t            ctl;
    logic [XLEN-1:0] result;
    logic            misalign;
  } memory_data_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [7:0]        strobe;
    logic [63:0]       data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   addrAccepted;
  } dbg_t;

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic isAligned(input logic [2:0] offset, input msize_t size);
    logic ok;
    case (size)
      MSIZE1:  ok = 1'b1;
      MSIZE2:  ok = (offset[0] == 1'b0);
      MSIZE4:  ok = (offset[1:0] == 2'b00);
      MSIZE8:  ok = (offset == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/memory_access_memdata_align.sv
// Byte-lane formatting for the data bus: store strobe/data placement and
// load-data extraction with sign or zero extension.
module memdata_align
  import memory_access_pkg::*;
(
  input  logic [2:0]      storeOffset,
  input  msize_t          storeSize,
  input  logic [XLEN-1:0] storeIn,
  output logic [7:0]      strobe,
  output logic [63:0]     storeOut,
  input  logic [2:0]      loadOffset,
  input  msize_t          loadSize,
  input  logic            loadSext,
  input  logic [63:0]     loadIn,
  output logic [XLEN-1:0] loadOut
);

  logic [7:0]  sizeMask;
  logic [63:0] shifted;

  always_comb begin
    case (storeSize)
      MSIZE1:  sizeMask = 8'h01;
      MSIZE2:  sizeMask = 8'h03;
      MSIZE4:  sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
    strobe   = sizeMask << storeOffset;
    storeOut = storeIn << {storeOffset, 3'b000};
  end

  // Bring the addressed lane down to bit 0, then truncate and extend.
  always_comb begin
    shifted = loadIn >> {loadOffset, 3'b000};
    case (loadSize)
      MSIZE1:  loadOut = {{56{loadSext & shifted[7]}},  shifted[7:0]};
      MSIZE2:  loadOut = {{48{loadSext & shifted[15]}}, shifted[15:0]};
      MSIZE4:  loadOut = {{32{loadSext & shifted[31]}}, shifted[31:0]};
      default: loadOut = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores on the data bus, stalls the front of the
// pipeline while an access is outstanding and hands results to writeback.
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  input  logic          downstream_stall,
  output memory_data_t  dataM,
  output logic          stallM,
  output dbg_t          dbg
);

  // Handshakes: a dataM result is consumed in a cycle with dataM.valid=1 and
  // downstream_stall=0; a bus request is live while dreq.valid=1 and holds
  // every field until the cycle dresp.data_ok=1, which ends it.

  state_t       state, stateNext;
  dbus_req_t    reqQ;
  logic [63:0]  pcQ;
  logic [4:0]   dstQ;
  ctl_t         ctlQ;
  memory_data_t holdQ, completed;
  logic         addrAcceptedQ;

  logic            isMemOp, aligned, accept, capture;
  logic [7:0]      storeStrobe;
  logic [63:0]     storeData;
  logic [XLEN-1:0] loadData;

  assign isMemOp = dataE.valid && (dataE.ctl.memread || dataE.ctl.memwrite);
  assign aligned = isAligned(dataE.alu_out[2:0], dataE.ctl.msize);

  memdata_align uAlign (
    .storeOffset (dataE.alu_out[2:0]),
    .storeSize   (dataE.ctl.msize),
    .storeIn     (dataE.srcb),
    .strobe      (storeStrobe),
    .storeOut    (storeData),
    .loadOffset  (reqQ.addr[2:0]),
    .loadSize    (reqQ.size),
    .loadSext    (ctlQ.memsext),
    .loadIn      (dresp.data),
    .loadOut     (loadData)
  );

  // Result of the outstanding access, valid in the data_ok cycle.
  always_comb begin
    completed          = '0;
    completed.valid    = 1'b1;
    completed.pc       = pcQ;
    completed.dst      = dstQ;
    completed.ctl      = ctlQ;
    completed.result   = ctlQ.memread ? loadData : '0;
    completed.misalign = 1'b0;
  end

  always_comb begin
    stateNext      = state;
    stallM         = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    dataM          = '0;
    dataM.valid    = dataE.valid;
    dataM.pc       = dataE.pc;
    dataM.dst      = dataE.dst;
    dataM.ctl      = dataE.ctl;
    dataM.result   = dataE.alu_out;
    dataM.misalign = 1'b0;
    case (state)
      IDLE: begin
        if (isMemOp) begin
          if (!aligned) begin
            dataM.misalign = 1'b1;
          end else begin
            accept      = 1'b1;
            stallM      = 1'b1;
            dataM.valid = 1'b0;
            stateNext   = BUSY;
          end
        end
      end
      BUSY: begin
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (dresp.data_ok) begin
          if (downstream_stall) begin
            capture   = 1'b1;
            stateNext = DONE;
          end else begin
            dataM     = completed;
            stallM    = 1'b0;
            stateNext = IDLE;
          end
        end
      end
      DONE: begin
        // Replay the held result; dataE is still the finished op, so no reissue.
        dataM  = holdQ;
        stallM = downstream_stall;
        if (!downstream_stall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      reqQ          <= '0;
      pcQ           <= '0;
      dstQ          <= '0;
      ctlQ          <= '0;
      holdQ         <= '0;
      addrAcceptedQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        reqQ.valid    <= 1'b1;
        reqQ.addr     <= dataE.alu_out[ADDR_W-1:0];
        reqQ.size     <= dataE.ctl.msize;
        reqQ.strobe   <= dataE.ctl.memwrite ? storeStrobe : 8'h00;
        reqQ.data     <= storeData;
        pcQ           <= dataE.pc;
        dstQ          <= dataE.dst;
        ctlQ          <= dataE.ctl;
        addrAcceptedQ <= 1'b0;
      end else if (state == BUSY) begin
        if (dresp.data_ok) reqQ.valid <= 1'b0;
        if (dresp.addr_ok) addrAcceptedQ <= 1'b1;
      end
      if (capture) holdQ <= completed;
    end
  end

  assign dreq             = reqQ;
  assign dbg.state        = state;
  assign dbg.addrAccepted = addrAcceptedQ;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus random ops against
// a byte-addressed reference memory, with a scoreboard on dataM.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          downstream_stall;
  memory_data_t  dataM;
  logic          stallM;
  dbg_t          dbg;

  int checks = 0;
  int errors = 0;

  // {check_result, misalign, result}
  logic [65:0] exp_q[$];

  logic [7:0]  byte_mem [longint];
  logic [63:0] word_mem [longint];

  int        req_cnt, stall_cnt, done_cnt;
  logic      unstable;
  dbus_req_t first_req;

  memory_access dut (
    .clk              (clk),
    .reset            (reset),
    .dataE            (dataE),
    .dreq             (dreq),
    .dresp            (dresp),
    .downstream_stall (downstream_stall),
    .dataM            (dataM),
    .stallM           (stallM),
    .dbg              (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input longint a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [7:0] model_byte(input logic [63:0] a);
    if (byte_mem.exists(longint'(a))) return byte_mem[longint'(a)];
    return init_byte(longint'(a));
  endfunction

  function automatic logic [63:0] bus_word(input longint w);
    logic [63:0] r;
    if (word_mem.exists(w)) return word_mem[w];
    for (int b = 0; b < 8; b++) r[8*b +: 8] = init_byte(w * 8 + b);
    return r;
  endfunction

  task automatic set_byte(input logic [63:0] a, input logic [7:0] v);
    logic [63:0] wv;
    int off;
    byte_mem[longint'(a)] = v;
    wv = bus_word(longint'(a >> 3));
    off = int'(a[2:0]);
    wv[8*off +: 8] = v;
    word_mem[longint'(a >> 3)] = wv;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [65:0] e;
    if (!reset && dataM.valid && !downstream_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h, expected no output", dataM.result);
      end else begin
        e = exp_q.pop_front();
        check("misalign", 64'(dataM.misalign), 64'(e[64]));
        if (e[65]) check("result", dataM.result, e[63:0]);
      end
    end
  end

  // kind: 0 = ALU (addr is the ALU value), 1 = load, 2 = store
  task automatic do_op(input int kind, input logic [63:0] addr, input msize_t size,
                       input logic sext, input logic [63:0] srcb, input int delay,
                       input int stall);
    int n, off, w, left, cyc;
    logic mis, mem, ok_given, fin;
    logic [63:0] v, exp_data, lane_mask, wv;
    logic [7:0] exp_strobe;
    longint key;
    n = 1 << int'(size);
    off = int'(addr[2:0]);
    mis = (kind != 0) && ((addr % 64'(n)) != 0);
    mem = (kind != 0) && !mis;
    exp_strobe = 8'h00;
    exp_data = '0;
    lane_mask = '0;
    if (!mem) begin
      exp_q.push_back({~mis, mis, addr});
    end else if (kind == 1) begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_byte(addr + 64'(i));
      if (sext && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hff;
      exp_q.push_back({1'b1, 1'b0, v});
    end else begin
      for (int i = 0; i < n; i++) begin
        byte_mem[longint'(addr + 64'(i))] = srcb[8*i +: 8];
        exp_strobe[off+i] = 1'b1;
        exp_data[8*(off+i) +: 8] = srcb[8*i +: 8];
        lane_mask[8*(off+i) +: 8] = 8'hff;
      end
      exp_q.push_back({1'b1, 1'b0, 64'h0});
    end

    dataE.valid        = 1'b1;
    dataE.pc           = {$urandom, $urandom};
    dataE.alu_out      = addr;
    dataE.srcb         = srcb;
    dataE.dst          = 5'($urandom_range(1, 31));
    dataE.ctl.regwrite = (kind != 2);
    dataE.ctl.memread  = (kind == 1);
    dataE.ctl.memwrite = (kind == 2);
    dataE.ctl.memsext  = sext;
    dataE.ctl.msize    = size;

    req_cnt = 0; stall_cnt = 0; done_cnt = 0; unstable = 1'b0;
    w = 0; left = stall; cyc = 0; ok_given = 1'b0; fin = 1'b0;
    while (!fin) begin
      dresp.addr_ok = 1'b0;
      dresp.data_ok = 1'b0;
      dresp.data    = {$urandom, $urandom};
      if (dreq.valid && !ok_given) begin
        if (w == delay) begin
          key = longint'(dreq.addr >> 3);
          dresp.addr_ok = 1'b1;
          dresp.data_ok = 1'b1;
          wv = bus_word(key);
          dresp.data = wv;
          if (dreq.strobe != 8'h00) begin
            for (int b = 0; b < 8; b++) if (dreq.strobe[b]) wv[8*b +: 8] = dreq.data[8*b +: 8];
            word_mem[key] = wv;
          end
          ok_given = 1'b1;
        end else begin
          dresp.addr_ok = 1'($urandom_range(0, 1));
        end
        w++;
      end
      if (mem && !ok_given) downstream_stall = 1'($urandom_range(0, 1));
      else if (left > 0) begin
        downstream_stall = 1'b1;
        left--;
      end else downstream_stall = 1'b0;

      @(negedge clk);
      if (dreq.valid) begin
        if (req_cnt == 0) first_req = dreq;
        else if (dreq !== first_req) unstable = 1'b1;
        req_cnt++;
      end
      stall_cnt += int'(stallM);
      done_cnt  += int'(dbg.state == DONE);
      if (!stallM && !downstream_stall) fin = 1'b1;
      cyc++;
      if (!fin && cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: got no completion after %0d cycles, expected completion", cyc);
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    dataE.valid = 1'b0;
    dresp = '0;
    downstream_stall = 1'b0;

    check("req_cycles", 64'(req_cnt), mem ? 64'(delay + 1) : 64'd0);
    check("stall_cycles", 64'(stall_cnt), mem ? 64'(1 + delay + stall) : 64'd0);
    check("done_cycles", 64'(done_cnt), mem ? 64'(stall) : 64'd0);
    check("req_stable", 64'(unstable), 64'd0);
    if (mem) begin
      check("req_addr", first_req.addr, addr);
      check("req_size", 64'(first_req.size), 64'(size));
      check("req_strobe", 64'(first_req.strobe), 64'(exp_strobe));
      if (kind == 2) check("req_data", first_req.data & lane_mask, exp_data);
    end
  endtask

  task automatic reset_mid_busy();
    dataE.valid        = 1'b1;
    dataE.pc           = 64'h1000;
    dataE.alu_out      = 64'h80000010;
    dataE.srcb         = '0;
    dataE.dst          = 5'd7;
    dataE.ctl.regwrite = 1'b1;
    dataE.ctl.memread  = 1'b1;
    dataE.ctl.memwrite = 1'b0;
    dataE.ctl.memsext  = 1'b0;
    dataE.ctl.msize    = MSIZE8;
    dresp = '0;
    downstream_stall = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_state", 64'(dbg.state), 64'(BUSY));
    check("rst_pre_dreq_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    dataE.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
    check("rst_state", 64'(dbg.state), 64'(IDLE));
    check("rst_stallM", 64'(stallM), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] word;
    int kind;
    reset = 1'b1;
    dataE = '0;
    dresp = '0;
    downstream_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dreq_valid", 64'(dreq.valid), 64'd0);
    check("reset_dreq_strobe", 64'(dreq.strobe), 64'd0);
    check("reset_state", 64'(dbg.state), 64'(IDLE));
    check("reset_stallM", 64'(stallM), 64'd0);
    check("reset_dataM_valid", 64'(dataM.valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LD with data_ok three cycles after dreq.valid
    word = 64'h1122334455667788;
    for (int b = 0; b < 8; b++) set_byte(64'h80000008 + 64'(b), word[8*b +: 8]);
    do_op(1, 64'h80000008, MSIZE8, 1'b0, 64'h0, 3, 0);
    check("ld_stall_4", 64'(stall_cnt), 64'd4);

    // LB signed and unsigned of 0x80
    set_byte(64'h80000003, 8'h80);
    do_op(1, 64'h80000003, MSIZE1, 1'b1, 64'h0, 1, 0);
    do_op(1, 64'h80000003, MSIZE1, 1'b0, 64'h0, 0, 0);

    // SH at offset 6
    do_op(2, 64'h80000006, MSIZE2, 1'b0, 64'hABCD, 2, 0);
    check("sh_strobe", 64'(first_req.strobe), 64'hC0);
    check("sh_data_hi", 64'(first_req.data[63:48]), 64'hABCD);
    check("sh_size", 64'(first_req.size), 64'(MSIZE2));
    do_op(1, 64'h80000006, MSIZE2, 1'b0, 64'h0, 0, 0);

    // misaligned LW
    do_op(1, 64'h80000002, MSIZE4, 1'b1, 64'h0, 0, 0);

    // data_ok under downstream stall for two cycles
    do_op(1, 64'h80000008, MSIZE8, 1'b0, 64'h0, 1, 2);
    check("stalled_done_cycles", 64'(done_cnt), 64'd2);

    reset_mid_busy();
    do_op(0, 64'h0000_0000_dead_beef, MSIZE1, 1'b0, 64'h0, 0, 0);
    check("add_stallM", 64'(stall_cnt), 64'd0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      do_op(kind,
            (kind == 0) ? {$urandom, $urandom} : 64'h80000000 + 64'($urandom_range(0, 255)),
            msize_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
